// File: rtl/cache_port_arbiter_if.sv
// ============================================================================
// cache_port_arbiter_if
// ----------------------------------------------------------------------------
// Purpose : Bundles everything that passes through the cache port arbiter.
//           This covers both requester ports (p0 = load/store unit,
//           p1 = DMA/debug master) and the single shared data-cache port.
//
// Parameters:
//   ADDR_W - byte address width forwarded to the cache
//   DATA_W - width of write_data / read_data
//
// Signal summary (directions as seen by the arbiter, modport slave):
//   p0_* / p1_*  requester side
//       addr, write_data, memwrite, memread, sign_mask  -> into arbiter
//       read_data, done, stall                          <- out of arbiter
//   c_*          cache side
//       c_addr, c_write_data, c_memwrite, c_memread,
//       c_sign_mask                                     <- out of arbiter
//       c_read_data, c_clk_stall                        -> into arbiter
//
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters + cache) driving the arbiter
// ============================================================================
interface cache_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_write_data;
    logic              p0_memwrite;
    logic              p0_memread;
    logic [3:0]        p0_sign_mask;
    logic [DATA_W-1:0] p0_read_data;
    logic              p0_done;
    logic              p0_stall;

    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_write_data;
    logic              p1_memwrite;
    logic              p1_memread;
    logic [3:0]        p1_sign_mask;
    logic [DATA_W-1:0] p1_read_data;
    logic              p1_done;
    logic              p1_stall;

    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_write_data;
    logic              c_memwrite;
    logic              c_memread;
    logic [3:0]        c_sign_mask;
    logic [DATA_W-1:0] c_read_data;
    logic              c_clk_stall;

    modport slave (
        input  p0_addr, p0_write_data, p0_memwrite, p0_memread, p0_sign_mask,
        output p0_read_data, p0_done, p0_stall,
        input  p1_addr, p1_write_data, p1_memwrite, p1_memread, p1_sign_mask,
        output p1_read_data, p1_done, p1_stall,
        output c_addr, c_write_data, c_memwrite, c_memread, c_sign_mask,
        input  c_read_data, c_clk_stall
    );

    modport master (
        output p0_addr, p0_write_data, p0_memwrite, p0_memread, p0_sign_mask,
        input  p0_read_data, p0_done, p0_stall,
        output p1_addr, p1_write_data, p1_memwrite, p1_memread, p1_sign_mask,
        input  p1_read_data, p1_done, p1_stall,
        input  c_addr, c_write_data, c_memwrite, c_memread, c_sign_mask,
        output c_read_data, c_clk_stall
    );
endinterface

// File: rtl/cache_port_arbiter.sv
// ============================================================================
// cache_port_arbiter
// ----------------------------------------------------------------------------
// Purpose : Shares the single data-cache port between two requesters using
//           round-robin arbitration with one transaction in flight. A held
//           request becomes a one-cycle cache pulse. The arbiter then waits
//           out c_clk_stall and returns read data plus a one-cycle done
//           pulse to the granted port.
//
// Parameters:
//   ADDR_W    - address width forwarded to the cache (default 32)
//   DATA_W    - data width (default 32)
//   INIT_LAST - last-grant value after reset; 1 gives port 0 first priority
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - cache_port_arbiter_if.slave (requester ports + cache port)
//
// Optional feature (macro CACHE_PORT_ARBITER_STATS_EN):
//   This macro adds the saturating 16-bit counters stat_grants0,
//   stat_grants1 and stat_conflicts as extra outputs.
// ============================================================================
module cache_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter bit INIT_LAST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cache_port_arbiter_if.slave  bus
`ifdef CACHE_PORT_ARBITER_STATS_EN
    ,
    output logic [15:0]          stat_grants0,
    output logic [15:0]          stat_grants1,
    output logic [15:0]          stat_conflicts
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state;
    logic              last_grant;
    logic              grant;
    logic              op_write;

    logic              req0;
    logic              req1;
    logic              both_req;
    logic              sel_port;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [3:0]        sel_mask;

    // A port requests when either op is raised. With both ops raised the
    // access is treated as a write.
    assign req0     = bus.p0_memread | bus.p0_memwrite;
    assign req1     = bus.p1_memread | bus.p1_memwrite;
    assign both_req = req0 & req1;

    // Round-robin pick. On a tie the port that was not served last wins.
    // Otherwise the single requester wins. The value does not matter when
    // nobody requests because IDLE ignores it.
    assign sel_port = both_req ? ~last_grant : ~req0;

    // Request mux feeding the cache registers at grant time
    always_comb begin
        sel_write = bus.p0_memwrite;
        sel_addr  = bus.p0_addr;
        sel_wdata = bus.p0_write_data;
        sel_mask  = bus.p0_sign_mask;
        if (sel_port) begin
            sel_write = bus.p1_memwrite;
            sel_addr  = bus.p1_addr;
            sel_wdata = bus.p1_write_data;
            sel_mask  = bus.p1_sign_mask;
        end
    end

    // A requester is stalled for as long as it holds a request. This
    // includes the time spent waiting for the other port's transaction.
    // The stall lifts only in the cycle its own done pulse is shown.
    assign bus.p0_stall = req0 & ~bus.p0_done;
    assign bus.p1_stall = req1 & ~bus.p1_done;

    // Main transaction FSM. All cache-side and requester-side outputs are
    // registered here. c_addr, c_write_data and c_sign_mask are written only
    // on a grant, so they hold steady from ISSUE through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            last_grant       <= INIT_LAST;
            grant            <= 1'b0;
            op_write         <= 1'b0;
            bus.c_addr       <= '0;
            bus.c_write_data <= '0;
            bus.c_memwrite   <= 1'b0;
            bus.c_memread    <= 1'b0;
            bus.c_sign_mask  <= '0;
            bus.p0_read_data <= '0;
            bus.p1_read_data <= '0;
            bus.p0_done      <= 1'b0;
            bus.p1_done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        bus.c_addr       <= sel_addr;
                        bus.c_write_data <= sel_wdata;
                        bus.c_sign_mask  <= sel_mask;
                        bus.c_memwrite   <= sel_write;
                        bus.c_memread    <= ~sel_write;
                        op_write         <= sel_write;
                        grant            <= sel_port;
                        last_grant       <= sel_port;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.c_memwrite <= 1'b0;
                    bus.c_memread  <= 1'b0;
                    state          <= WAIT;
                end
                WAIT: begin
                    if (!bus.c_clk_stall) begin
                        // Only reads update the granted port's data register
                        if (!op_write) begin
                            if (grant) begin
                                bus.p1_read_data <= bus.c_read_data;
                            end else begin
                                bus.p0_read_data <= bus.c_read_data;
                            end
                        end
                        if (grant) begin
                            bus.p1_done <= 1'b1;
                        end else begin
                            bus.p0_done <= 1'b1;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Requests are not sampled here, which gives the
                    // requester one cycle to drop its request.
                    bus.p0_done <= 1'b0;
                    bus.p1_done <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_PORT_ARBITER_STATS_EN
    logic grant_fire;

    assign grant_fire = (state == IDLE) && (req0 | req1);

    // Grant and conflict counters. Each one saturates at all-ones rather
    // than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_grants0   <= '0;
            stat_grants1   <= '0;
            stat_conflicts <= '0;
        end else if (grant_fire) begin
            if (!sel_port && stat_grants0 != 16'hFFFF) begin
                stat_grants0 <= stat_grants0 + 16'd1;
            end
            if (sel_port && stat_grants1 != 16'hFFFF) begin
                stat_grants1 <= stat_grants1 + 16'd1;
            end
            if (both_req && stat_conflicts != 16'hFFFF) begin
                stat_conflicts <= stat_conflicts + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
// ============================================================================
// tb_cache_port_arbiter
// ----------------------------------------------------------------------------
// Bench for cache_port_arbiter. Queued requests are driven onto the
// requester ports. The cache is modelled with a configurable stall length.
// Each transaction is pushed to an expectation queue when it is driven,
// then popped when the cache pulse and the done pulse appear.
// Define CACHE_PORT_ARBITER_STATS_EN to also check the statistics counters.
// ============================================================================
module tb_cache_port_arbiter;

    typedef struct {
        logic        port;
        logic        memread;
        logic        memwrite;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] rdata;
        int          stall;
        int          exp_lat;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n;

    cache_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef CACHE_PORT_ARBITER_STATS_EN
    logic [15:0] stat_grants0;
    logic [15:0] stat_grants1;
    logic [15:0] stat_conflicts;
`endif

    cache_port_arbiter #(.ADDR_W(32), .DATA_W(32), .INIT_LAST(1'b1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus)
`ifdef CACHE_PORT_ARBITER_STATS_EN
        ,
        .stat_grants0   (stat_grants0),
        .stat_grants1   (stat_grants1),
        .stat_conflicts (stat_conflicts)
`endif
    );

    // 10 ns clock
    always #5 clk = ~clk;

    int          checks = 0;
    int          passes = 0;
    txn_t        pend_q0[$];
    txn_t        pend_q1[$];
    txn_t        exp_q0[$];
    txn_t        exp_q1[$];
    txn_t        done_q[$];
    int          grant_log[$];
    bit          active0 = 1'b0;
    bit          active1 = 1'b0;
    int          start0 = 0;
    int          start1 = 0;
    int          cycle = 0;
    bit          model_last = 1'b1;
    logic [31:0] model_rd0 = '0;
    logic [31:0] model_rd1 = '0;
    int          stall_cnt = 0;
    bit          prev_pulse = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s: observed 'h%0h expected 'h%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic port, input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] mask, input logic [31:0] rdata,
                                 input int stall, input int lat);
        txn_t t;
        t.port = port; t.memread = rd; t.memwrite = wr; t.addr = addr;
        t.wdata = wdata; t.mask = mask; t.rdata = rdata; t.stall = stall;
        t.exp_lat = lat;
        if (port) pend_q1.push_back(t);
        else      pend_q0.push_back(t);
    endtask

    // Load the next queued request for a port, or drop its request
    task automatic driveNext(input logic port);
        txn_t t;
        if (!port) begin
            if (pend_q0.size() > 0) begin
                t = pend_q0.pop_front();
                bus.p0_memread = t.memread; bus.p0_memwrite = t.memwrite;
                bus.p0_addr = t.addr; bus.p0_write_data = t.wdata;
                bus.p0_sign_mask = t.mask;
                exp_q0.push_back(t); active0 = 1'b1; start0 = cycle;
            end else begin
                bus.p0_memread = 1'b0; bus.p0_memwrite = 1'b0; bus.p0_addr = '0;
                bus.p0_write_data = '0; bus.p0_sign_mask = '0; active0 = 1'b0;
            end
        end else begin
            if (pend_q1.size() > 0) begin
                t = pend_q1.pop_front();
                bus.p1_memread = t.memread; bus.p1_memwrite = t.memwrite;
                bus.p1_addr = t.addr; bus.p1_write_data = t.wdata;
                bus.p1_sign_mask = t.mask;
                exp_q1.push_back(t); active1 = 1'b1; start1 = cycle;
            end else begin
                bus.p1_memread = 1'b0; bus.p1_memwrite = 1'b0; bus.p1_addr = '0;
                bus.p1_write_data = '0; bus.p1_sign_mask = '0; active1 = 1'b0;
            end
        end
    endtask

    // Per-negedge scoreboard, cache model and requester driver
    task automatic serviceNegedge();
        txn_t t;
        logic gport;
        logic d0;
        logic d1;
        cycle++;
        d0 = bus.p0_done;
        d1 = bus.p1_done;
        if (prev_pulse) begin
            checkOutput("pulse_width_wr", 32'(bus.c_memwrite), 32'd0);
            checkOutput("pulse_width_rd", 32'(bus.c_memread), 32'd0);
        end
        checkOutput("p0_stall", 32'(bus.p0_stall), 32'(active0 && !d0));
        checkOutput("p1_stall", 32'(bus.p1_stall), 32'(active1 && !d1));

        if (bus.c_memwrite === 1'b1 || bus.c_memread === 1'b1) begin
            prev_pulse = 1'b1;
            if (!active0 && !active1) begin
                checkOutput("issue_unexpected",
                            32'(bus.c_memwrite | bus.c_memread), 32'd0);
            end else begin
                gport = (active0 && active1) ? ~model_last : active1;
                model_last = gport;
                checkOutput("issue_queue_depth",
                            32'(gport ? exp_q1.size() : exp_q0.size()), 32'd1);
                if ((gport ? exp_q1.size() : exp_q0.size()) > 0) begin
                    t = gport ? exp_q1.pop_front() : exp_q0.pop_front();
                    checkOutput("c_memwrite", 32'(bus.c_memwrite), 32'(t.memwrite));
                    checkOutput("c_memread", 32'(bus.c_memread), 32'(!t.memwrite));
                    checkOutput("c_addr", bus.c_addr, t.addr);
                    checkOutput("c_write_data", bus.c_write_data, t.wdata);
                    checkOutput("c_sign_mask", 32'(bus.c_sign_mask), 32'(t.mask));
                    done_q.push_back(t);
                    stall_cnt = t.stall;
                    bus.c_read_data = t.rdata;
                end
            end
        end else begin
            prev_pulse = 1'b0;
            bus.c_clk_stall = (stall_cnt > 0);
            if (stall_cnt > 0) stall_cnt--;
        end

        if (d0 === 1'b1 || d1 === 1'b1) begin
            checkOutput("done_queue_depth", 32'(done_q.size()), 32'd1);
            if (done_q.size() > 0) begin
                t = done_q.pop_front();
                checkOutput("done_p0", 32'(d0), 32'(t.port == 1'b0));
                checkOutput("done_p1", 32'(d1), 32'(t.port == 1'b1));
                checkOutput("c_addr_hold", bus.c_addr, t.addr);
                if (!t.memwrite) begin
                    if (t.port) model_rd1 = t.rdata;
                    else        model_rd0 = t.rdata;
                end
                checkOutput("p0_read_data", bus.p0_read_data, model_rd0);
                checkOutput("p1_read_data", bus.p1_read_data, model_rd1);
                if (t.exp_lat >= 0) begin
                    checkOutput("latency", 32'(cycle - (t.port ? start1 : start0)),
                                32'(t.exp_lat));
                end
                grant_log.push_back(int'(t.port));
                driveNext(t.port);
            end
        end
        if (!active0) driveNext(1'b0);
        if (!active1) driveNext(1'b1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) serviceNegedge();
        end
    end

    // Bounded wait until every queued transaction has completed
    task automatic waitIdle();
        int n = 0;
        while ((active0 || active1 || pend_q0.size() > 0 || pend_q1.size() > 0 ||
                done_q.size() > 0) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("drain_in_time", 32'(n < 200), 32'd1);
    endtask

    initial begin
        int   exp_order[4] = '{0, 1, 0, 1};
        bit   seen;
        rst_n = 1'b0;
        bus.c_clk_stall = 1'b0;
        bus.c_read_data = '0;
        driveNext(1'b0);
        driveNext(1'b1);

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_c_addr", bus.c_addr, 32'd0);
        checkOutput("rst_c_write_data", bus.c_write_data, 32'd0);
        checkOutput("rst_c_memwrite", 32'(bus.c_memwrite), 32'd0);
        checkOutput("rst_c_memread", 32'(bus.c_memread), 32'd0);
        checkOutput("rst_c_sign_mask", 32'(bus.c_sign_mask), 32'd0);
        checkOutput("rst_p0_done", 32'(bus.p0_done), 32'd0);
        checkOutput("rst_p1_done", 32'(bus.p1_done), 32'd0);
        checkOutput("rst_p0_read_data", bus.p0_read_data, 32'd0);
        checkOutput("rst_p1_read_data", bus.p1_read_data, 32'd0);
        #1;
        rst_n = 1'b1;

        // Contention: both ports request at once, two transactions each
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h100, 32'h11, 4'b0111, 32'hDEADBEEF, 1, -1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h104, 32'h0, 4'b0111, 32'h00001234, 1, -1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 4'b0111, 32'h00005678, 1, -1);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h204, 32'h22, 4'b0111, 32'hDEADBEEF, 1, -1);
        waitIdle();
        checkOutput("grant_count", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < grant_log.size()) begin
                checkOutput($sformatf("grant_order[%0d]", i), 32'(grant_log[i]),
                            32'(exp_order[i]));
            end
        end
`ifdef CACHE_PORT_ARBITER_STATS_EN
        checkOutput("stat_grants0", 32'(stat_grants0), 32'd2);
        checkOutput("stat_grants1", 32'(stat_grants1), 32'd2);
        checkOutput("stat_conflicts", 32'(stat_conflicts), 32'd3);
`endif
        grant_log.delete();

        // Single write, no stall: 3-cycle latency
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h400, 32'hAAA, 4'b0001, 32'hDEADBEEF, 0, 3);
        waitIdle();
        // Signed byte read, 5 stall cycles: 8-cycle latency
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h400, 32'h0, 4'b1001, 32'hFFFFFFAA, 5, 8);
        waitIdle();
        // Both ops raised on p1: treated as a write, read data untouched
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h40, 32'hAAAAAAAA, 4'b0111, 32'h12345678, 0, 3);
        waitIdle();
        // Plain p1 halfword read with 2 stall cycles
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 4'b0011, 32'hCAFE0011, 2, 5);
        waitIdle();

        // Reset in the middle of a stalled read on p0
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h80, 32'h0, 4'b0111, 32'h0BADF00D, 20, -1);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (bus.c_clk_stall === 1'b1) seen = 1'b1;
        end
        checkOutput("mid_reset_stall_seen", 32'(seen), 32'd1);
        #1;
        rst_n = 1'b0;
        pend_q0.delete(); pend_q1.delete(); exp_q0.delete(); exp_q1.delete();
        done_q.delete(); grant_log.delete();
        driveNext(1'b0);
        driveNext(1'b1);
        stall_cnt = 0; bus.c_clk_stall = 1'b0; prev_pulse = 1'b0;
        model_last = 1'b1; model_rd0 = '0; model_rd1 = '0;
        #1;
        checkOutput("mid_rst_c_addr", bus.c_addr, 32'd0);
        checkOutput("mid_rst_c_memread", 32'(bus.c_memread), 32'd0);
        checkOutput("mid_rst_c_memwrite", 32'(bus.c_memwrite), 32'd0);
        checkOutput("mid_rst_c_sign_mask", 32'(bus.c_sign_mask), 32'd0);
        checkOutput("mid_rst_p0_done", 32'(bus.p0_done), 32'd0);
        checkOutput("mid_rst_p1_done", 32'(bus.p1_done), 32'd0);
        checkOutput("mid_rst_p0_read_data", bus.p0_read_data, 32'd0);
        checkOutput("mid_rst_p1_read_data", bus.p1_read_data, 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // After reset, a tie goes to p0 first again
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h300, 32'h33, 4'b0111, 32'hDEADBEEF, 0, -1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h304, 32'h44, 4'b0111, 32'hDEADBEEF, 0, -1);
        waitIdle();
        checkOutput("post_rst_grant_count", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() >= 2) begin
            checkOutput("post_rst_first_grant", 32'(grant_log[0]), 32'd0);
            checkOutput("post_rst_second_grant", 32'(grant_log[1]), 32'd1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Shares the single data-cache port (addr, write_data, memwrite, memread, sign_mask, read_data, clk_stall) between two requesters: port 0 is the processor load/store unit, port 1 is a DMA/debug master.
- Round-robin arbitration, one transaction in flight at a time.
- Converts each requester's level-held request into the cache's one-cycle request pulse, then waits out clk_stall.
- Returns read data plus a one-cycle done pulse to the granted requester.

Parameters:
- ADDR_W, 32, address width forwarded to the cache.
- DATA_W, 32, data width of write_data and read_data.
- INIT_LAST, 1, value of the last-grant register after reset; default 1 gives port 0 first priority.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- p0_addr / p1_addr  in  ADDR_W  requester byte address.
- p0_write_data / p1_write_data  in  DATA_W  store data.
- p0_memwrite / p1_memwrite  in  1  write request, held until done.
- p0_memread / p1_memread  in  1  read request, held until done.
- p0_sign_mask / p1_sign_mask  in  4  bit3 = signed load; bits2:0 = size (001 byte, 011 half, 111 word).
- p0_read_data / p1_read_data  out  DATA_W  registered load result.
- p0_done / p1_done  out  1  one-cycle completion pulse.
- p0_stall / p1_stall  out  1  request pending and not yet done (combinational).
- c_addr  out  ADDR_W  cache address.
- c_write_data  out  DATA_W  cache store data.
- c_memwrite  out  1  cache write pulse.
- c_memread  out  1  cache read pulse.
- c_sign_mask  out  4  cache access mask.
- c_read_data  in  DATA_W  cache load result.
- c_clk_stall  in  1  cache busy.

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE.
- Reset (asynchronous on rst_n low):
  - state = IDLE, last_grant = INIT_LAST.
  - All c_* outputs = 0.
  - pN_read_data = 0, pN_done = 0.
  - Any in-flight transaction is abandoned. Cache internal state is not touched.
- Requests: reqN = pN_memread | pN_memwrite. If both are high, the transaction is a write and memread is ignored.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both ports requesting: grant the port that is not last_grant.
  - On grant: latch addr, write_data, sign_mask and op into the c_* registers, set grant = port, update last_grant, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - c_memwrite or c_memread is high for this cycle only; go to WAIT.
  - c_addr, c_write_data and c_sign_mask hold their latched values from ISSUE through DONE.
- WAIT:
  - c_memread and c_memwrite are 0.
  - Stay in WAIT while c_clk_stall = 1.
  - On the first WAIT cycle with c_clk_stall = 0:
    - Reads: capture c_read_data into p{grant}_read_data.
    - Writes: p{grant}_read_data is unchanged.
    - Go to DONE.
- DONE (1 cycle):
  - p{grant}_done = 1.
  - Requests are not sampled; go to IDLE.
  - The requester must drop its request by the next edge. A request still held in IDLE is treated as a new transaction.
- Latency:
  - Minimum request-to-done is 3 cycles: IDLE grant edge, ISSUE, WAIT with stall already low.
  - Total latency = 3 + number of WAIT cycles with c_clk_stall high.
- pN_stall = reqN & ~(pN_done).
  - A requester stalls through its own transaction and while the other port is being served.
- Fairness: under continuous requests from both ports, grants strictly alternate (0,1,0,1…). The losing port waits at most one transaction.
- Sign extension and byte lanes are handled by the cache. The arbiter forwards sign_mask unmodified.
- pN_read_data of the non-granted port is never modified.

Optional Feature:
- Macro: CACHE_PORT_ARBITER_STATS_EN.
- Defined:
  - Adds outputs stat_grants0 [15:0], stat_grants1 [15:0] and stat_conflicts [15:0].
  - stat_grantsN increments on each IDLE→ISSUE grant to port N.
  - stat_conflicts increments on each grant made while both ports request.
  - All three saturate at 16'hFFFF and reset to 0 on rst_n.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Single write:
  - Stimulus: p0 memwrite, addr 32'h400, write_data 32'hAAA, sign_mask 4'b0001; cache stall 0 cycles.
  - Response: c_memwrite is high for exactly 1 cycle with c_addr = 32'h400; p0_done pulses 3 cycles after the request.
- Read with stall:
  - Stimulus: p0 memread, addr 32'h400, sign_mask 4'b1001; c_clk_stall high for 5 cycles; c_read_data = 32'hFFFFFFAA.
  - Response: p0_read_data = 32'hFFFFFFAA coincident with p0_done at cycle 8; p0_stall high for cycles 0–7.
- Contention:
  - Stimulus: p0 and p1 both request in the same cycle after reset.
  - Response: p0 is served first, then p1; grant order under a sustained 4-request load is 0,1,0,1.
- Both ops asserted:
  - Stimulus: p1 with memread = memwrite = 1, addr 32'h40, write_data 32'hAAAAAAAA, sign_mask 4'b0111.
  - Response: only c_memwrite pulses; p1_read_data is unchanged.
- Reset mid-operation:
  - Stimulus: rst_n pulled low while in WAIT with c_clk_stall high.
  - Response: c_* outputs and pN_done are 0 immediately; after release, the first grant goes to p0.
- Stats (with CACHE_PORT_ARBITER_STATS_EN):
  - Stimulus: the contention scenario above.
  - Response: stat_grants0 = 2, stat_grants1 = 2, stat_conflicts ≥ 1.
